// File: rtl/local_memory_pkg.sv
// Shared definitions for the local memory controller: FSM state encoding,
// the value presented on an idle read-data bus and the two port indices.
package local_memory_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DATA   = 2'd2
    } state_t;

    localparam logic [31:0] DATA_IDLE_VALUE = 32'hFFFF_FFFF;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/local_memory_arbiter.sv
// Two-requester round-robin arbiter. On a tie the port that was not granted
// most recently wins. The history flag only moves when an access completes,
// so an abandoned (reset) access does not change fairness.
module local_memory_arbiter
    import local_memory_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_complete,
    input  logic i_complete_index,
    output logic o_grant_valid,
    output logic o_grant_index
);

    logic r_lastGrant;

    // Pick a requester; a tie goes to the port opposite the last completed grant
    always_comb begin
        o_grant_valid = i_req_a | i_req_b;
        if (i_req_a && i_req_b) begin
            o_grant_index = ~r_lastGrant;
        end else if (i_req_a) begin
            o_grant_index = PORT_A;
        end else begin
            o_grant_index = PORT_B;
        end
    end

    // Remember which port finished last; starts at B so A wins the first tie
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lastGrant <= PORT_B;
        end else if (i_complete) begin
            r_lastGrant <= i_complete_index;
        end
    end

endmodule

// File: rtl/local_memory_controller.sv
// Local memory controller: arbitrates the Wishbone-side request port (A) and
// the core data port (B) onto NUM_BANKS single-port 32-bit SRAM macros.
// The granted request drives the SRAM in the same cycle it is seen; the
// following cycle completes the access.
// Optional build macro EXPERIAR_LOCAL_MEMORY_READ_REGISTER_EN registers the
// read data in an extra DATA cycle (reads take two cycles instead of one).
module local_memory_controller
    import local_memory_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int NUM_BANKS  = 2
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,

    input  logic [23:0]               a_address,
    input  logic [3:0]                a_byteSelect,
    input  logic                      a_writeEnable,
    input  logic                      a_readEnable,
    input  logic [31:0]               a_dataWrite,
    output logic [31:0]               a_dataRead,
    output logic                      a_busy,

    input  logic [23:0]               b_address,
    input  logic [3:0]                b_byteSelect,
    input  logic                      b_writeEnable,
    input  logic                      b_readEnable,
    input  logic [31:0]               b_dataWrite,
    output logic [31:0]               b_dataRead,
    output logic                      b_busy,

    output logic [NUM_BANKS-1:0]      sram_csb,
    output logic                      sram_web,
    output logic [3:0]                sram_wmask,
    output logic [ADDR_WIDTH-1:0]     sram_addr,
    output logic [31:0]               sram_din,
    input  logic [32*NUM_BANKS-1:0]   sram_dout
);

    localparam int          BANK_BITS  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [31:0] WORD_LIMIT = 32'(NUM_BANKS) << ADDR_WIDTH;

    state_t                 r_state;
    logic                   r_grant;
    logic                   r_write;
    logic                   r_inRange;
    logic [BANK_BITS-1:0]   r_bank;
`ifdef EXPERIAR_LOCAL_MEMORY_READ_REGISTER_EN
    logic [31:0]            r_readData;
`endif

    logic                   w_reqA;
    logic                   w_reqB;
    logic                   w_grantValid;
    logic                   w_grantIndex;
    logic                   w_issue;
    logic                   w_completing;
    logic                   w_selWrite;
    logic [3:0]             w_selByteSel;
    logic [31:0]            w_selData;
    logic [31:0]            w_selWord;
    logic [BANK_BITS-1:0]   w_selBank;
    logic                   w_selInRange;
    logic [31:0]            w_bankData;
    logic [31:0]            w_readSlice;
    logic [31:0]            w_readValue;
    logic                   w_unusedByteOffset;

    assign w_reqA = a_writeEnable | a_readEnable;
    assign w_reqB = b_writeEnable | b_readEnable;

    // Byte-offset bits are irrelevant to a word-organised memory
    assign w_unusedByteOffset = ^{a_address[1:0], b_address[1:0]};

    local_memory_arbiter u_arbiter (
        .i_clk            (wb_clk_i),
        .i_rst            (wb_rst_i),
        .i_req_a          (w_reqA),
        .i_req_b          (w_reqB),
        .i_complete       (w_completing),
        .i_complete_index (r_grant),
        .o_grant_valid    (w_grantValid),
        .o_grant_index    (w_grantIndex)
    );

    // Route the currently granted port's request fields and decode its bank
    always_comb begin
        if (w_grantIndex == PORT_A) begin
            w_selWrite   = a_writeEnable;
            w_selByteSel = a_byteSelect;
            w_selData    = a_dataWrite;
            w_selWord    = {10'd0, a_address[23:2]};
        end else begin
            w_selWrite   = b_writeEnable;
            w_selByteSel = b_byteSelect;
            w_selData    = b_dataWrite;
            w_selWord    = {10'd0, b_address[23:2]};
        end
        w_selBank    = w_selWord[ADDR_WIDTH +: BANK_BITS];
        w_selInRange = (w_selWord < WORD_LIMIT);
    end

    // Only an idle controller out of reset may start an SRAM cycle
    assign w_issue = (r_state == ST_IDLE) && w_grantValid && !wb_rst_i;

    // Drive the SRAM macros straight from the granted request, otherwise idle
    always_comb begin
        sram_csb   = '1;
        sram_web   = 1'b1;
        sram_wmask = 4'b0000;
        sram_addr  = '0;
        sram_din   = 32'd0;
        if (w_issue) begin
            sram_web   = ~w_selWrite;
            sram_wmask = w_selWrite ? w_selByteSel : 4'b0000;
            sram_addr  = w_selWord[ADDR_WIDTH-1:0];
            sram_din   = w_selData;
            if (w_selInRange) begin
                for (int k = 0; k < NUM_BANKS; k++) begin
                    if (w_selBank == BANK_BITS'(k)) begin
                        sram_csb[k] = 1'b0;
                    end
                end
            end
        end
    end

    // Select the read-data slice of the bank that was accessed last cycle
    always_comb begin
        w_bankData = DATA_IDLE_VALUE;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (r_bank == BANK_BITS'(k)) begin
                w_bankData = sram_dout[32*k +: 32];
            end
        end
        w_readSlice = r_inRange ? w_bankData : DATA_IDLE_VALUE;
    end

    // Decide whether the granted access finishes in this cycle
    always_comb begin
        w_completing = 1'b0;
        if (!wb_rst_i) begin
            case (r_state)
`ifdef EXPERIAR_LOCAL_MEMORY_READ_REGISTER_EN
                ST_ACCESS: w_completing = r_write;
`else
                ST_ACCESS: w_completing = 1'b1;
`endif
                ST_DATA:   w_completing = 1'b1;
                default:   w_completing = 1'b0;
            endcase
        end
    end

`ifdef EXPERIAR_LOCAL_MEMORY_READ_REGISTER_EN
    assign w_readValue = r_readData;
`else
    assign w_readValue = w_readSlice;
`endif

    // Per-port handshake: busy until this port's own access completes
    always_comb begin
        a_busy     = w_reqA && !(w_completing && (r_grant == PORT_A));
        b_busy     = w_reqB && !(w_completing && (r_grant == PORT_B));
        a_dataRead = DATA_IDLE_VALUE;
        b_dataRead = DATA_IDLE_VALUE;
        if (w_completing && !r_write) begin
            if (r_grant == PORT_A) begin
                a_dataRead = w_readValue;
            end else begin
                b_dataRead = w_readValue;
            end
        end
    end

    // Access sequencer: latch the grant on issue, then finish or register read data
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state    <= ST_IDLE;
            r_grant    <= PORT_A;
            r_write    <= 1'b0;
            r_inRange  <= 1'b0;
            r_bank     <= '0;
`ifdef EXPERIAR_LOCAL_MEMORY_READ_REGISTER_EN
            r_readData <= DATA_IDLE_VALUE;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grantValid) begin
                        r_grant   <= w_grantIndex;
                        r_write   <= w_selWrite;
                        r_inRange <= w_selInRange;
                        r_bank    <= w_selBank;
                        r_state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
`ifdef EXPERIAR_LOCAL_MEMORY_READ_REGISTER_EN
                    if (r_write) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_readData <= w_readSlice;
                        r_state    <= ST_DATA;
                    end
`else
                    r_state <= ST_IDLE;
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_local_memory_controller.sv
// Scoreboard bench for local_memory_controller: stimulus pushes the expected
// completion cycle and read data per port, a negedge monitor pops and compares
// whenever a requesting port sees busy drop. A behavioural SRAM model sits on
// the bank interface (registered read data, masked writes).
module tb_local_memory_controller;

    localparam int ADDR_WIDTH = 9;
    localparam int NUM_BANKS  = 2;
    localparam logic [31:0] IDLE = 32'hFFFF_FFFF;
`ifdef EXPERIAR_LOCAL_MEMORY_READ_REGISTER_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    typedef struct {
        bit          isRead;
        logic [31:0] data;
        int          cycle;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [23:0]               a_address = '0, b_address = '0;
    logic [3:0]                a_byteSelect = '0, b_byteSelect = '0;
    logic                      a_writeEnable = 1'b0, b_writeEnable = 1'b0;
    logic                      a_readEnable = 1'b0, b_readEnable = 1'b0;
    logic [31:0]               a_dataWrite = '0, b_dataWrite = '0;
    logic [31:0]               a_dataRead, b_dataRead;
    logic                      a_busy, b_busy;
    logic [NUM_BANKS-1:0]      sram_csb;
    logic                      sram_web;
    logic [3:0]                sram_wmask;
    logic [ADDR_WIDTH-1:0]     sram_addr;
    logic [31:0]               sram_din;
    logic [32*NUM_BANKS-1:0]   sram_dout;

    logic [31:0] mem [NUM_BANKS][1<<ADDR_WIDTH];
    logic [31:0] doutReg [NUM_BANKS];
    logic [31:0] maskBits;

    exp_t expA[$];
    exp_t expB[$];
    int   cycle = 0;
    int   total = 0;
    int   bad   = 0;

    local_memory_controller #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_BANKS  (NUM_BANKS)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .a_address     (a_address),
        .a_byteSelect  (a_byteSelect),
        .a_writeEnable (a_writeEnable),
        .a_readEnable  (a_readEnable),
        .a_dataWrite   (a_dataWrite),
        .a_dataRead    (a_dataRead),
        .a_busy        (a_busy),
        .b_address     (b_address),
        .b_byteSelect  (b_byteSelect),
        .b_writeEnable (b_writeEnable),
        .b_readEnable  (b_readEnable),
        .b_dataWrite   (b_dataWrite),
        .b_dataRead    (b_dataRead),
        .b_busy        (b_busy),
        .sram_csb      (sram_csb),
        .sram_web      (sram_web),
        .sram_wmask    (sram_wmask),
        .sram_addr     (sram_addr),
        .sram_din      (sram_din),
        .sram_dout     (sram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Behavioural single-port SRAM banks with registered read data
    assign maskBits  = {{8{sram_wmask[3]}}, {8{sram_wmask[2]}}, {8{sram_wmask[1]}}, {8{sram_wmask[0]}}};
    assign sram_dout = {doutReg[1], doutReg[0]};

    initial begin
        for (int k = 0; k < NUM_BANKS; k++) begin
            doutReg[k] = 32'd0;
            for (int i = 0; i < (1 << ADDR_WIDTH); i++) mem[k][i] = 32'd0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (!sram_csb[k]) begin
                if (!sram_web)
                    mem[k][sram_addr] <= (mem[k][sram_addr] & ~maskBits) | (sram_din & maskBits);
                else
                    doutReg[k] <= mem[k][sram_addr];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    task automatic checkPins(input string name, input logic [1:0] csb, input logic web,
                             input logic [3:0] wmask, input logic [31:0] addr, input logic [31:0] din);
        check({name, " csb"},   32'(sram_csb),   32'(csb));
        check({name, " web"},   32'(sram_web),   32'(web));
        check({name, " wmask"}, 32'(sram_wmask), 32'(wmask));
        check({name, " addr"},  32'(sram_addr),  addr);
        check({name, " din"},   sram_din,        din);
    endtask

    function automatic void pushExp(input bit port, input bit isRead, input logic [31:0] data, input int cyc);
        exp_t e;
        e.isRead = isRead;
        e.data   = data;
        e.cycle  = cyc;
        if (port) expB.push_back(e);
        else      expA.push_back(e);
    endfunction

    task automatic setPort(input bit port, input logic we, input logic re, input logic [23:0] addr,
                           input logic [3:0] sel, input logic [31:0] data);
        if (!port) begin
            a_writeEnable = we; a_readEnable = re; a_address = addr; a_byteSelect = sel; a_dataWrite = data;
        end else begin
            b_writeEnable = we; b_readEnable = re; b_address = addr; b_byteSelect = sel; b_dataWrite = data;
        end
    endtask

    // Raise a request in the current cycle and record its expected completion
    task automatic applyStimulus(input bit port, input logic we, input logic re, input logic [23:0] addr,
                                 input logic [3:0] sel, input logic [31:0] data,
                                 input logic [31:0] expData, input int lat);
        setPort(port, we, re, addr, sel, data);
        pushExp(port, re && !we, expData, cycle + lat);
    endtask

    // Hold the request through 'count' completions, then drop it
    task automatic waitDone(input bit port, input int count);
        bit seen;
        for (int i = 0; i < count; i++) begin
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(negedge clk);
                if (!(port ? b_busy : a_busy)) seen = 1'b1;
            end
            if (!seen) begin
                total++;
                bad++;
                $display("[TB] FAIL timeout port=%0d actual=busy required=complete", port);
            end
        end
        @(posedge clk);
        #1;
        setPort(port, 1'b0, 1'b0, 24'd0, 4'd0, 32'd0);
    endtask

    task automatic checkOutput(input bit port, input logic req, input logic busy, input logic [31:0] rd);
        exp_t e;
        if (req && !busy) begin
            if ((!port && expA.size() == 0) || (port && expB.size() == 0)) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected completion port=%0d cycle=%0d actual=complete required=none", port, cycle);
            end else begin
                e = port ? expB.pop_front() : expA.pop_front();
                check(port ? "B completion cycle" : "A completion cycle", 32'(cycle), 32'(e.cycle));
                if (e.isRead) check(port ? "B read data" : "A read data", rd, e.data);
            end
        end else if (req) begin
            check(port ? "B idle dataRead" : "A idle dataRead", rd, IDLE);
        end
    endtask

    // Monitor: compare every completion against the scoreboard
    always @(negedge clk) begin
        checkOutput(1'b0, a_writeEnable | a_readEnable, a_busy, a_dataRead);
        checkOutput(1'b1, b_writeEnable | b_readEnable, b_busy, b_dataRead);
    end

    initial begin
        $display("[TB] local_memory_controller bench, read latency %0d", L);

        // Reset values, and a request presented during reset must not reach the SRAM
        @(posedge clk); #1;
        checkPins("reset", 2'b11, 1'b1, 4'h0, 32'd0, 32'd0);
        check("reset A dataRead", a_dataRead, IDLE);
        check("reset B dataRead", b_dataRead, IDLE);
        check("reset A busy idle", 32'(a_busy), 32'd0);
        setPort(1'b0, 1'b1, 1'b1, 24'h000800, 4'hF, 32'hA5A5A5A5);
        #1;
        checkPins("reset with request", 2'b11, 1'b1, 4'h0, 32'd0, 32'd0);
        check("reset A busy requested", 32'(a_busy), 32'd1);
        setPort(1'b0, 1'b0, 1'b0, 24'd0, 4'd0, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Full write then read back
        applyStimulus(1'b0, 1'b1, 1'b0, 24'h000010, 4'hF, 32'hDEADBEEF, 32'd0, 1);
        #1 checkPins("A write", 2'b10, 1'b0, 4'hF, 32'd4, 32'hDEADBEEF);
        waitDone(1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 24'h000010, 4'hF, 32'd0, 32'hDEADBEEF, L);
        #1 checkPins("A read", 2'b10, 1'b1, 4'h0, 32'd4, 32'd0);
        waitDone(1'b0, 1);

        // Byte lane write merges into existing word
        applyStimulus(1'b0, 1'b1, 1'b0, 24'h000010, 4'b0010, 32'h0000AB00, 32'd0, 1);
        #1 checkPins("A byte write", 2'b10, 1'b0, 4'b0010, 32'd4, 32'h0000AB00);
        waitDone(1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 24'h000010, 4'hF, 32'd0, 32'hDEADABEF, L);
        waitDone(1'b0, 1);

        // Bank 0 word 0 and bank 1 word 0 hold different data
        applyStimulus(1'b0, 1'b1, 1'b0, 24'h000000, 4'hF, 32'hCAFEF00D, 32'd0, 1);
        waitDone(1'b0, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 24'h000800, 4'hF, 32'h12345678, 32'd0, 1);
        #1 checkPins("B bank1 write", 2'b01, 1'b0, 4'hF, 32'd0, 32'h12345678);
        waitDone(1'b1, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 24'h000800, 4'hF, 32'd0, 32'h12345678, L);
        #1 checkPins("A bank1 read", 2'b01, 1'b1, 4'h0, 32'd0, 32'd0);
        waitDone(1'b0, 1);

        // Out of range: no chip select, read is idle value, write is dropped
        applyStimulus(1'b0, 1'b0, 1'b1, 24'h001000, 4'hF, 32'd0, IDLE, L);
        #1 check("out of range read csb", 32'(sram_csb), 32'h3);
        waitDone(1'b0, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 24'h001000, 4'hF, 32'h55555555, 32'd0, 1);
        #1 check("out of range write csb", 32'(sram_csb), 32'h3);
        waitDone(1'b1, 1);
        applyStimulus(1'b1, 1'b0, 1'b1, 24'h000000, 4'hF, 32'd0, 32'hCAFEF00D, L);
        waitDone(1'b1, 1);

        // First tie: A wins, B follows after A's access
        applyStimulus(1'b0, 1'b0, 1'b1, 24'h000010, 4'hF, 32'd0, 32'hDEADABEF, L);
        applyStimulus(1'b1, 1'b0, 1'b1, 24'h000800, 4'hF, 32'd0, 32'h12345678, 2*L + 1);
        #1 check("tie1 grant csb", 32'(sram_csb), 32'h2);
        fork
            waitDone(1'b0, 1);
            waitDone(1'b1, 1);
        join

        // A alone, then a second tie goes to B
        applyStimulus(1'b0, 1'b0, 1'b1, 24'h000000, 4'hF, 32'd0, 32'hCAFEF00D, L);
        waitDone(1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 24'h000800, 4'hF, 32'd0, 32'h12345678, 2*L + 1);
        applyStimulus(1'b1, 1'b0, 1'b1, 24'h000010, 4'hF, 32'd0, 32'hDEADABEF, L);
        #1 check("tie2 grant csb", 32'(sram_csb), 32'h2);
        fork
            waitDone(1'b0, 1);
            waitDone(1'b1, 1);
        join

        // B holds RE across three back-to-back accesses
        applyStimulus(1'b1, 1'b0, 1'b1, 24'h000010, 4'hF, 32'd0, 32'hDEADABEF, L);
        pushExp(1'b1, 1'b1, 32'hDEADABEF, cycle + L + (L + 1));
        pushExp(1'b1, 1'b1, 32'hDEADABEF, cycle + L + 2*(L + 1));
        waitDone(1'b1, 3);

        // Reset during ACCESS abandons the read; the held request is served afterwards
        setPort(1'b0, 1'b0, 1'b1, 24'h000800, 4'hF, 32'd0);
        #1 check("pre-reset read csb", 32'(sram_csb), 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkPins("mid-access reset", 2'b11, 1'b1, 4'h0, 32'd0, 32'd0);
        check("mid-access reset A busy", 32'(a_busy), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        pushExp(1'b0, 1'b1, 32'h12345678, cycle + L);
        #1 check("reissued read csb", 32'(sram_csb), 32'h1);
        waitDone(1'b0, 1);

        repeat (3) @(posedge clk);
        check("A scoreboard drained", 32'(expA.size()), 32'd0);
        check("B scoreboard drained", 32'(expB.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
